pe_mac_accum: RTL and testbench
===============================

PE_MAC_ACCUM -- requirements
Module: pe_mac_accum

Interface
REQ-001 The block SHALL have parameter ACC_DEPTH, default 16, the number of accumulator entries (power of two, 2..128).
REQ-002 The block SHALL have parameter ACC_W, default 40, the accumulator width in bits (signed, ≥32).
REQ-003 The block SHALL have port i_clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-004 The block SHALL have port i_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have ports i_left_ready and i_right_ready, input, 1 bit each: the encoder's buffer-ready levels.
REQ-006 The block SHALL have ports i_left_addr and i_right_addr, input, 63 bits each: lane j at bits [21j+20:21j]; within a lane, x [6:0], y [13:7], k [20:14].
REQ-007 The block SHALL have ports i_left_w and i_right_w, input, 48 bits each: signed 16-bit weight, lane j at bits [16j+15:16j].
REQ-008 The block SHALL have ports i_left_ia and i_right_ia, input, 48 bits each: signed 16-bit activation, same packing as the weights.
REQ-009 The block SHALL have port i_clear, input, 1 bit: synchronous clear of all state.
REQ-010 The block SHALL have port i_rd_en, input, 1 bit, and port i_rd_idx, input, $clog2(ACC_DEPTH) bits: the accumulator read request.
REQ-011 The block SHALL have port o_rd_data, output, ACC_W bits, and port o_rd_valid, output, 1 bit: the read response.
REQ-012 The block SHALL have port o_busy, output, 1 bit: high when the FSM is not in IDLE or any pending flag is set.
REQ-013 The block SHALL have ports o_overrun and o_sat, output, 1 bit each: sticky error flags.
REQ-014 The block SHALL have port o_group_cnt, output, 16 bits: the count of completed groups, wrapping.

Function
REQ-015 The block SHALL detect a rising edge per side: the sampled ready is 1 and the ready value registered on the previous cycle is 0.
REQ-016 On a side's rising edge the block SHALL snapshot that side's addr, w and ia into the side's slot and set its pending flag, unless the flag is already set.
REQ-017 If a rising edge arrives while the side's pending flag is set, the slot SHALL keep its old data, the new data SHALL be dropped, and o_overrun SHALL be set.
REQ-018 The FSM SHALL have states IDLE, MUL and DRAIN.
REQ-019 IDLE SHALL select a pending slot; when both are pending it SHALL take the side not served last, with left first after reset.
REQ-020 Selection in IDLE SHALL clear that slot's pending flag and move to MUL with lane=0.
REQ-021 MUL SHALL run 3 cycles; each cycle it SHALL register the 32-bit signed product w[lane]*ia[lane] and k index k[lane][$clog2(ACC_DEPTH)-1:0], then increment lane.
REQ-022 After lane 2, MUL SHALL move to DRAIN; DRAIN SHALL last 1 cycle and then return to IDLE.
REQ-023 The product register SHALL be added, sign-extended, to acc[k index] on the cycle after it is captured (the cycles after the MUL edges, i.e. MUL cycles 2-3 and DRAIN).
REQ-024 Lanes with the same k SHALL accumulate sequentially with no lost update.
REQ-025 The accumulator add SHALL saturate to the signed ACC_W range, and any saturation SHALL set o_sat.
REQ-026 Zero-padded lanes (ia=0) SHALL be processed normally and contribute 0.
REQ-027 Latency: with IDLE and no pending work, a rising edge sampled at clock edge E0 SHALL produce its final acc update at E4, and o_group_cnt SHALL increment at E4.
REQ-028 The minimum group spacing SHALL be 5 cycles.
REQ-029 A rising edge on a side SHALL be captured even while a group from the same side is in flight.
REQ-030 A read SHALL be served when i_rd_en=1 at edge E: o_rd_data = acc[i_rd_idx] as it was before E, and o_rd_valid=1 for 1 cycle.
REQ-031 o_rd_valid SHALL be 0 when no read is requested, and reads SHALL be accepted in every state.
REQ-032 i_clear=1 SHALL take priority over all other activity.
REQ-033 On i_clear=1 at an edge, the block SHALL zero all accumulators, pending flags, product registers, o_overrun, o_sat and o_group_cnt, abort any in-flight group, go to IDLE, and set the last-served pointer to right.
REQ-034 A ready rising edge in the same cycle as i_clear=1 SHALL be ignored.

Reset
REQ-035 While i_rst_n=0 the block SHALL hold the FSM in IDLE, the last-served pointer at right, and the registered previous readies at 0.
REQ-036 While i_rst_n=0 the block SHALL hold every accumulator, slot, pending flag and product register at 0.
REQ-037 While i_rst_n=0 the block SHALL hold o_rd_data=0, o_rd_valid=0, o_busy=0, o_overrun=0, o_sat=0 and o_group_cnt=0.
REQ-038 Reset asserted mid-group SHALL discard the group with no partial update kept.
REQ-039 A ready held high through reset release SHALL count as a rising edge on the first clock edge after release.

Verification
REQ-040 The bench SHALL cover a single group: left rise with w={2,3,-4}, ia={5,7,1}, k={1,1,2} -> at E4 acc[1]=31, acc[2]=-4, o_group_cnt=1; read idx 1 -> o_rd_data=31 one cycle later.
REQ-041 The bench SHALL cover a simultaneous rise: left and right rise in the same cycle -> left processed first, right starts at E5 and completes at E9, o_group_cnt=2, o_overrun=0.
REQ-042 The bench SHALL cover overrun: left rises, falls, and rises again twice while busy -> second snapshot kept, third dropped, o_overrun=1, and exactly 2 left groups accumulate.
REQ-043 The bench SHALL cover saturation: ACC_W=40, acc[0] preloaded via 2^24 groups of 32767*32767, or a forced ACC_W=33 build -> acc clamps at max positive and o_sat=1.
REQ-044 The bench SHALL cover clear mid-group: i_clear during MUL lane 1 -> all acc=0, o_busy=0 next cycle, and no later update from the aborted group.
REQ-045 The bench SHALL cover zero padding: right rise with ia={9,0,0}, w={1,5,5}, k={3,3,3} -> acc[3]=9.

Source files
------------

// File: rtl/pe_mac_accum.sv
// Processing-element MAC accumulator. Each side (left/right) delivers a
// 3-lane bundle of weights, activations and accumulator indices; a rising
// edge on the side's ready level snapshots the bundle. A small FSM
// multiplies the lanes one per cycle and adds each product into a
// saturating accumulator file on the following cycle.
module pe_mac_accum #(
  parameter int ACC_DEPTH = 16,
  parameter int ACC_W     = 40
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_left_ready,
  input  logic                         i_right_ready,
  input  logic [62:0]                  i_left_addr,
  input  logic [62:0]                  i_right_addr,
  input  logic [47:0]                  i_left_w,
  input  logic [47:0]                  i_right_w,
  input  logic [47:0]                  i_left_ia,
  input  logic [47:0]                  i_right_ia,
  input  logic                         i_clear,
  input  logic                         i_rd_en,
  input  logic [$clog2(ACC_DEPTH)-1:0] i_rd_idx,
  output logic [ACC_W-1:0]             o_rd_data,
  output logic                         o_rd_valid,
  output logic                         o_busy,
  output logic                         o_overrun,
  output logic                         o_sat,
  output logic [15:0]                  o_group_cnt
);
  localparam int IDX_W  = $clog2(ACC_DEPTH);
  localparam int DATA_W = 16;
  localparam int PROD_W = 2 * DATA_W;
  localparam int LANES  = 3;
  localparam int KW     = LANES * IDX_W;

  typedef enum logic [1:0] {IDLE, MUL, DRAIN} state_t;

  state_t                   state;
  logic [1:0]               lane;
  logic                     last_right;
  logic                     rdy_l_q, rdy_r_q;
  logic                     pend_l, pend_r;
  logic [KW-1:0]            slot_l_k, slot_r_k, work_k;
  logic [47:0]              slot_l_w, slot_r_w, slot_l_ia, slot_r_ia;
  logic [47:0]              work_w, work_ia;
  logic signed [PROD_W-1:0] prod_p1;
  logic [IDX_W-1:0]         kidx_p1;
  logic                     vld_p1;
  logic signed [ACC_W-1:0]  acc [ACC_DEPTH];

  logic                     rise_l, rise_r, cap_l, cap_r, avail_l, avail_r;
  logic                     sel_l, sel_r;
  logic [KW-1:0]            k_in_l, k_in_r;
  logic signed [DATA_W-1:0] w_lane, ia_lane;
  logic [IDX_W-1:0]         k_lane;
  logic signed [PROD_W-1:0] prod_c;
  logic signed [ACC_W:0]    sum_p1;
  logic                     unused_addr;

  // x/y coordinates and the upper k bits play no part in accumulation
  assign unused_addr = ^{i_left_addr, i_right_addr};

  // Overflow of the one-bit-wider sum shows up as disagreeing top bits
  function automatic logic sat_hit(input logic [ACC_W:0] s);
    return s[ACC_W] != s[ACC_W-1];
  endfunction

  // Clamp the one-bit-wider sum back into the signed accumulator range
  function automatic logic signed [ACC_W-1:0] saturate(input logic [ACC_W:0] s);
    if (s[ACC_W] != s[ACC_W-1])
      return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return s[ACC_W-1:0];
  endfunction

  // Edge detection, overrun/capture decision and round-robin selection
  always_comb begin
    rise_l  = i_left_ready & ~rdy_l_q;
    rise_r  = i_right_ready & ~rdy_r_q;
    cap_l   = rise_l & ~pend_l;
    cap_r   = rise_r & ~pend_r;
    avail_l = pend_l | cap_l;
    avail_r = pend_r | cap_r;
    sel_l   = (state == IDLE) & avail_l & (~avail_r | last_right);
    sel_r   = (state == IDLE) & avail_r & ~sel_l;
  end

  // Pull the per-lane accumulator index out of each incoming address word
  always_comb begin
    k_in_l = '0;
    k_in_r = '0;
    for (int j = 0; j < LANES; j++) begin
      k_in_l[j*IDX_W +: IDX_W] = i_left_addr[21*j+14 +: IDX_W];
      k_in_r[j*IDX_W +: IDX_W] = i_right_addr[21*j+14 +: IDX_W];
    end
  end

  // Operands of the lane currently being multiplied
  always_comb begin
    w_lane  = $signed(work_w[DATA_W*int'(lane) +: DATA_W]);
    ia_lane = $signed(work_ia[DATA_W*int'(lane) +: DATA_W]);
    k_lane  = work_k[IDX_W*int'(lane) +: IDX_W];
    prod_c  = PROD_W'(w_lane) * PROD_W'(ia_lane);
  end

  // Sign-extended accumulate of the registered product
  always_comb begin
    sum_p1 = {acc[kidx_p1][ACC_W-1], acc[kidx_p1]}
           + {{(ACC_W+1-PROD_W){prod_p1[PROD_W-1]}}, prod_p1};
  end

  assign o_busy = (state != IDLE) | pend_l | pend_r;

  // Previous ready levels for rising-edge detection (updated even on clear,
  // so a ready that rose under clear is not seen as an edge afterwards)
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) {rdy_l_q, rdy_r_q} <= 2'b00;
    else          {rdy_l_q, rdy_r_q} <= {i_left_ready, i_right_ready};
  end

  // Slots, pending flags and the IDLE/MUL/DRAIN sequencer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE; lane <= 2'd0; last_right <= 1'b1;
      pend_l <= 1'b0; pend_r <= 1'b0; o_overrun <= 1'b0; o_group_cnt <= '0;
      slot_l_k <= '0; slot_l_w <= '0; slot_l_ia <= '0;
      slot_r_k <= '0; slot_r_w <= '0; slot_r_ia <= '0;
      work_k <= '0; work_w <= '0; work_ia <= '0;
    end else if (i_clear) begin
      state <= IDLE; lane <= 2'd0; last_right <= 1'b1;
      pend_l <= 1'b0; pend_r <= 1'b0; o_overrun <= 1'b0; o_group_cnt <= '0;
      slot_l_k <= '0; slot_l_w <= '0; slot_l_ia <= '0;
      slot_r_k <= '0; slot_r_w <= '0; slot_r_ia <= '0;
      work_k <= '0; work_w <= '0; work_ia <= '0;
    end else begin
      if (cap_l) begin slot_l_k <= k_in_l; slot_l_w <= i_left_w; slot_l_ia <= i_left_ia; end
      if (cap_r) begin slot_r_k <= k_in_r; slot_r_w <= i_right_w; slot_r_ia <= i_right_ia; end
      if ((rise_l & pend_l) | (rise_r & pend_r)) o_overrun <= 1'b1;
      pend_l <= avail_l & ~sel_l;
      pend_r <= avail_r & ~sel_r;
      case (state)
        IDLE: begin
          if (sel_l | sel_r) begin
            state      <= MUL;
            lane       <= 2'd0;
            last_right <= sel_r;
            // The working copy frees the slot for a new snapshot mid-group
            if (sel_l) begin
              work_k  <= cap_l ? k_in_l    : slot_l_k;
              work_w  <= cap_l ? i_left_w  : slot_l_w;
              work_ia <= cap_l ? i_left_ia : slot_l_ia;
            end else begin
              work_k  <= cap_r ? k_in_r     : slot_r_k;
              work_w  <= cap_r ? i_right_w  : slot_r_w;
              work_ia <= cap_r ? i_right_ia : slot_r_ia;
            end
          end
        end
        MUL: begin
          lane <= lane + 2'd1;
          if (lane == 2'd2) state <= DRAIN;
        end
        DRAIN: begin
          state       <= IDLE;
          o_group_cnt <= o_group_cnt + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p1: one registered product per MUL cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prod_p1 <= '0; kidx_p1 <= '0; vld_p1 <= 1'b0;
    end else if (i_clear) begin
      prod_p1 <= '0; kidx_p1 <= '0; vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= (state == MUL);
      if (state == MUL) begin
        prod_p1 <= prod_c;
        kidx_p1 <= k_lane;
      end
    end
  end

  // Stage p2: saturating accumulate into the indexed entry
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < ACC_DEPTH; i++) acc[i] <= '0;
      o_sat <= 1'b0;
    end else if (i_clear) begin
      for (int i = 0; i < ACC_DEPTH; i++) acc[i] <= '0;
      o_sat <= 1'b0;
    end else if (vld_p1) begin
      acc[kidx_p1] <= saturate(sum_p1);
      if (sat_hit(sum_p1)) o_sat <= 1'b1;
    end
  end

  // Registered read port returning the pre-edge accumulator value
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rd_data <= '0; o_rd_valid <= 1'b0;
    end else if (i_clear) begin
      o_rd_data <= '0; o_rd_valid <= 1'b0;
    end else begin
      o_rd_valid <= i_rd_en;
      if (i_rd_en) o_rd_data <= acc[i_rd_idx];
    end
  end
endmodule

// File: tb/tb_pe_mac_accum.sv
// Bench for pe_mac_accum: directed scenarios with literal expectations plus
// a randomized phase, all checked every cycle against a schedule-based model.
module tb_pe_mac_accum;
  localparam int     DEPTH   = 16;
  localparam int     AW      = 33;
  localparam int     IW      = 4;
  localparam longint ACC_MAX = (longint'(1) <<< (AW-1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) <<< (AW-1));

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          left_ready = 1'b0, right_ready = 1'b0;
  logic [62:0]   left_addr = '0, right_addr = '0;
  logic [47:0]   left_w = '0, right_w = '0, left_ia = '0, right_ia = '0;
  logic          clear = 1'b0, rd_en = 1'b0;
  logic [IW-1:0] rd_idx = '0;
  logic [AW-1:0] rd_data;
  logic          rd_valid, busy, overrun, sat;
  logic [15:0]   group_cnt;

  always #5 clk = ~clk;

  pe_mac_accum #(.ACC_DEPTH(DEPTH), .ACC_W(AW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_left_ready(left_ready), .i_right_ready(right_ready),
    .i_left_addr(left_addr), .i_right_addr(right_addr),
    .i_left_w(left_w), .i_right_w(right_w),
    .i_left_ia(left_ia), .i_right_ia(right_ia),
    .i_clear(clear), .i_rd_en(rd_en), .i_rd_idx(rd_idx),
    .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_busy(busy),
    .o_overrun(overrun), .o_sat(sat), .o_group_cnt(group_cnt)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A group started at edge S adds lane l at edge S+2+l, completes at S+4,
  // and the engine may start the next group from edge S+5.
  longint m_acc[DEPTH];
  bit     m_prev[2], m_pend[2], m_fly, m_last_r, m_ovr, m_sat, m_rdv;
  int     m_sw[2][3], m_sia[2][3], m_sk[2][3];
  int     g_w[3], g_ia[3], g_k[3];
  longint m_start, m_free_at, m_rdd, ecount = 0;
  int     m_cnt;

  function automatic int lane16(input logic [47:0] v, input int j);
    logic signed [15:0] x;
    x = v[16*j +: 16];
    return int'(x);
  endfunction

  function automatic int lanek(input logic [62:0] a, input int j);
    logic [6:0] k;
    k = a[21*j+14 +: 7];
    return int'(k) % DEPTH;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m_acc[i] = 0;
    m_pend[0] = 0; m_pend[1] = 0; m_fly = 0; m_free_at = 0;
    m_last_r = 1; m_ovr = 0; m_sat = 0; m_cnt = 0; m_rdv = 0; m_rdd = 0;
  endtask

  task automatic model_step();
    bit rdy[2];
    ecount++;
    rdy[0] = left_ready; rdy[1] = right_ready;
    if (!rst_n) begin
      model_clear(); m_prev[0] = 0; m_prev[1] = 0;
      return;
    end
    if (clear) begin
      model_clear(); m_prev = rdy;
      return;
    end
    m_rdv = rd_en;
    if (rd_en) m_rdd = m_acc[rd_idx];
    if (m_fly) begin
      longint d;
      d = ecount - m_start;
      if (d >= 2 && d <= 4) begin
        longint s;
        int l;
        l = int'(d) - 2;
        s = m_acc[g_k[l]] + longint'(g_w[l]) * longint'(g_ia[l]);
        if (s > ACC_MAX) begin s = ACC_MAX; m_sat = 1; end
        if (s < ACC_MIN) begin s = ACC_MIN; m_sat = 1; end
        m_acc[g_k[l]] = s;
      end
      if (d == 4) begin m_cnt = (m_cnt + 1) & 32'hFFFF; m_fly = 0; end
    end
    for (int s = 0; s < 2; s++) begin
      if (rdy[s] && !m_prev[s]) begin
        if (m_pend[s]) m_ovr = 1;
        else begin
          m_pend[s] = 1;
          for (int j = 0; j < 3; j++) begin
            m_sw[s][j]  = lane16(s == 0 ? left_w : right_w, j);
            m_sia[s][j] = lane16(s == 0 ? left_ia : right_ia, j);
            m_sk[s][j]  = lanek(s == 0 ? left_addr : right_addr, j);
          end
        end
      end
    end
    m_prev = rdy;
    if (!m_fly && ecount >= m_free_at && (m_pend[0] || m_pend[1])) begin
      int s;
      s = (m_pend[0] && (!m_pend[1] || m_last_r)) ? 0 : 1;
      for (int j = 0; j < 3; j++) begin
        g_w[j] = m_sw[s][j]; g_ia[j] = m_sia[s][j]; g_k[j] = m_sk[s][j];
      end
      m_pend[s] = 0; m_last_r = (s == 1); m_fly = 1;
      m_start = ecount; m_free_at = ecount + 5;
    end
  endtask

  // Every-cycle comparison of all outputs against the model
  always @(posedge clk) begin
    model_step();
    #1;
    chk("busy", longint'(busy), longint'(m_fly || m_pend[0] || m_pend[1]));
    chk("overrun", longint'(overrun), longint'(m_ovr));
    chk("sat", longint'(sat), longint'(m_sat));
    chk("group_cnt", longint'(group_cnt), longint'(m_cnt));
    chk("rd_valid", longint'(rd_valid), longint'(m_rdv));
    if (m_rdv || !rst_n) chk("rd_data", longint'($signed(rd_data)), m_rdd);
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_side(input bit side, input int w[3], input int ia[3], input int k[3]);
    logic [62:0] a;
    logic [47:0] wv, iv;
    a = 63'({$urandom(), $urandom()});
    for (int j = 0; j < 3; j++) begin
      a[21*j+14 +: 7] = 7'(k[j]);
      wv[16*j +: 16]  = 16'(w[j]);
      iv[16*j +: 16]  = 16'(ia[j]);
    end
    if (side == 0) begin left_addr = a; left_w = wv; left_ia = iv; end
    else begin right_addr = a; right_w = wv; right_ia = iv; end
  endtask

  task automatic read_chk(input string name, input int idx, input longint exp);
    rd_en = 1'b1; rd_idx = IW'(idx);
    cyc(1);
    rd_en = 1'b0;
    chk(name, longint'($signed(rd_data)), exp);
  endtask

  task automatic do_clear();
    clear = 1'b1; cyc(1); clear = 1'b0;
  endtask

  function automatic logic [47:0] rand_lanes();
    logic [47:0] v;
    for (int j = 0; j < 3; j++)
      v[16*j +: 16] = ($urandom_range(0, 7) == 0) ? 16'($urandom()) : 16'($urandom_range(0, 200) - 100);
    return v;
  endfunction

  initial begin
    // Reset
    cyc(3);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_cnt", longint'(group_cnt), 0);
    chk("rst_rd_valid", longint'(rd_valid), 0);
    rst_n = 1'b1;
    cyc(1);

    // Single left group
    set_side(0, '{2, 3, -4}, '{5, 7, 1}, '{1, 1, 2});
    left_ready = 1'b1; cyc(1); left_ready = 1'b0;          // after E0
    chk("g1_busy", longint'(busy), 1);
    cyc(3);                                                 // after E3
    chk("g1_cnt_e3", longint'(group_cnt), 0);
    read_chk("g1_acc2_before_e4", 2, 0);                    // read at E4
    chk("g1_cnt_e4", longint'(group_cnt), 1);
    read_chk("g1_acc2", 2, -4);
    read_chk("g1_acc1", 1, 31);
    do_clear();
    chk("clr_cnt", longint'(group_cnt), 0);
    read_chk("clr_acc1", 1, 0);

    // Simultaneous rise: left first, right starts at E5, done at E9
    set_side(0, '{1, 1, 1}, '{1, 1, 1}, '{4, 4, 4});
    set_side(1, '{2, 2, 2}, '{1, 1, 1}, '{5, 5, 5});
    left_ready = 1'b1; right_ready = 1'b1; cyc(1);
    left_ready = 1'b0; right_ready = 1'b0;                  // after E0
    cyc(4);
    chk("sim_cnt_e4", longint'(group_cnt), 1);
    cyc(4);
    chk("sim_cnt_e8", longint'(group_cnt), 1);
    chk("sim_busy_e8", longint'(busy), 1);
    cyc(1);
    chk("sim_cnt_e9", longint'(group_cnt), 2);
    chk("sim_busy_e9", longint'(busy), 0);
    chk("sim_overrun", longint'(overrun), 0);
    read_chk("sim_acc5", 5, 6);
    read_chk("sim_acc4", 4, 3);
    do_clear();

    // Overrun: second snapshot kept, third dropped
    set_side(0, '{1, 1, 1}, '{1, 1, 1}, '{6, 6, 6});
    left_ready = 1'b1; cyc(1); left_ready = 1'b0; cyc(1);
    set_side(0, '{10, 10, 10}, '{1, 1, 1}, '{6, 6, 6});
    left_ready = 1'b1; cyc(1); left_ready = 1'b0; cyc(1);
    set_side(0, '{100, 100, 100}, '{1, 1, 1}, '{6, 6, 6});
    left_ready = 1'b1; cyc(1); left_ready = 1'b0;
    chk("ovr_flag", longint'(overrun), 1);
    cyc(8);
    chk("ovr_cnt", longint'(group_cnt), 2);
    chk("ovr_busy", longint'(busy), 0);
    read_chk("ovr_acc6", 6, 33);

    // Clear during MUL lane 1
    set_side(0, '{5, 5, 5}, '{5, 5, 5}, '{7, 7, 7});
    left_ready = 1'b1; cyc(1); left_ready = 1'b0; cyc(1);  // after E1
    clear = 1'b1; cyc(1); clear = 1'b0;                     // clear at E2
    chk("clrmid_busy", longint'(busy), 0);
    chk("clrmid_ovr", longint'(overrun), 0);
    cyc(5);
    chk("clrmid_cnt", longint'(group_cnt), 0);
    read_chk("clrmid_acc7", 7, 0);
    read_chk("clrmid_acc6", 6, 0);

    // Zero-padded lanes
    set_side(1, '{1, 5, 5}, '{9, 0, 0}, '{3, 3, 3});
    right_ready = 1'b1; cyc(1); right_ready = 1'b0;
    cyc(5);
    read_chk("pad_acc3", 3, 9);
    chk("pad_cnt", longint'(group_cnt), 1);

    // Saturation at both ends of the 33-bit range
    for (int rep = 0; rep < 2; rep++) begin
      set_side(0, '{32767, 32767, 32767}, '{32767, 32767, 32767}, '{0, 0, 0});
      set_side(1, '{-32768, -32768, -32768}, '{32767, 32767, 32767}, '{1, 1, 1});
      left_ready = 1'b1; right_ready = 1'b1; cyc(1);
      left_ready = 1'b0; right_ready = 1'b0;
      cyc(9);
      if (rep == 0) begin
        chk("sat_not_yet", longint'(sat), 0);
        read_chk("sat_acc0_first", 0, 64'sd3221028867);
      end
    end
    chk("sat_flag", longint'(sat), 1);
    read_chk("sat_acc0_max", 0, ACC_MAX);
    read_chk("sat_acc1_min", 1, ACC_MIN);

    // Reset mid-group, ready held high through release
    set_side(0, '{4, 4, 4}, '{4, 4, 4}, '{9, 9, 9});
    left_ready = 1'b1; cyc(1); left_ready = 1'b0; cyc(2);
    rst_n = 1'b0; left_ready = 1'b1;
    cyc(1);
    set_side(0, '{2, 2, 2}, '{3, 3, 3}, '{8, 8, 8});
    cyc(1);
    chk("rstmid_cnt", longint'(group_cnt), 0);
    chk("rstmid_busy", longint'(busy), 0);
    rst_n = 1'b1; cyc(1); left_ready = 1'b0;
    chk("rel_busy", longint'(busy), 1);
    cyc(5);
    chk("rel_cnt", longint'(group_cnt), 1);
    read_chk("rel_acc9", 9, 0);
    read_chk("rel_acc8", 8, 18);

    // Randomized phase
    for (int c = 0; c < 4000; c++) begin
      int p;
      p = (c < 2000) ? 3 : 11;
      if ($urandom_range(0, p) == 0) left_ready = ~left_ready;
      if ($urandom_range(0, p) == 0) right_ready = ~right_ready;
      left_addr  = 63'({$urandom(), $urandom()});
      right_addr = 63'({$urandom(), $urandom()});
      left_w = rand_lanes(); left_ia = rand_lanes();
      right_w = rand_lanes(); right_ia = rand_lanes();
      rd_en  = 1'($urandom_range(0, 1));
      rd_idx = IW'($urandom());
      clear  = ($urandom_range(0, 299) == 0);
      if (clear) rd_en = 1'b0;
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 1'b0; cyc(2); rst_n = 1'b1;
      end
      cyc(1);
    end
    clear = 1'b0; rd_en = 1'b0; left_ready = 1'b0; right_ready = 1'b0;
    cyc(12);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
